cu_mem: RTL and testbench
=========================

CU_MEM -- requirements
Module: cu_mem

Interface
REQ-001 SHALL have ports: soc_clk  in  1  sole clock, all state changes on rising edge.
REQ-002 SHALL have: MEM_reset_n  in  1  synchronous, active-low reset.
REQ-003 SHALL have: MEM_stall  in  1  blocks capture in IDLE; holds DONE.
REQ-004 SHALL have: result_data  in  32  EX result (address for load/store; pass-through value otherwise).
REQ-005 SHALL have: result_ready  in  1  EX result valid this cycle.
REQ-006 SHALL have: store_data  in  32  rs2 value for stores.
REQ-007 SHALL have: mem_op  in  5  [4:3] 00=none, 01=load, 10=store, 11=invalid; [2:0] funct3 000=B, 001=H, 010=W, 100=BU, 101=HU.
REQ-008 SHALL have: dmem_req, dmem_we  out  1 each  request and write enable.
REQ-009 SHALL have: dmem_addr  out  32  word address {addr[31:2],2'b00}; dmem_wdata  out  32; dmem_wstrb  out  4.
REQ-010 SHALL have: dmem_rdata  in  32; dmem_ack  in  1  one-cycle completion pulse.
REQ-011 SHALL have: wb_data  out  32; wb_valid  out  1; wb_reg_write  out  1; mem_err  out  1; busy  out  1.

Function
REQ-012 SHALL implement FSM IDLE, REQ, DONE; busy = (state != IDLE).
REQ-013 IDLE: on edge with result_ready=1 and MEM_stall=0, SHALL latch result_data, store_data, mem_op; else remain IDLE.
REQ-014 On capture, op none -> DONE with wb_data=result_data, wb_reg_write=1, mem_err=0.
REQ-015 On capture, invalid class, invalid funct3 (011,110,111; stores also reject 1xx), H/HU with addr[0]=1, or W with addr[1:0]!=0 -> DONE with wb_data=0, wb_reg_write=0, mem_err=1; dmem_req never asserted.
REQ-016 Otherwise -> REQ; dmem_req=1 registered from the capture edge, dmem_we=1 for stores, address/wdata/wstrb stable until ack.
REQ-017 Store wdata/wstrb: B = {4{sd[7:0]}}, 4'b0001<<addr[1:0]; H = {2{sd[15:0]}}, 4'b0011<<addr[1:0]; W = sd, 4'b1111.
REQ-018 REQ: edge sampling dmem_ack=1 -> DONE, dmem_req/dmem_we<=0; loads latch rdata.
REQ-019 Load data: shift rdata right by 8*addr[1:0]; B/H sign-extend bit 7/15, BU/HU zero-extend, W unmodified; wb_reg_write=1.
REQ-020 Store completion: wb_data=0, wb_reg_write=0, mem_err=0.
REQ-021 REQ SHALL count cycles in 4-bit counter; 16th consecutive edge without ack -> DONE, dmem_req<=0, mem_err=1, wb_data=0, wb_reg_write=0.
REQ-022 MEM_stall in REQ SHALL NOT abort or pause the transaction.
REQ-023 DONE with MEM_stall=0: next edge wb_valid<=1 for exactly one cycle, state -> IDLE; with MEM_stall=1: hold DONE, wb_valid=0, results held.
REQ-024 wb_data, wb_reg_write, mem_err SHALL hold values until next completion.
REQ-025 result_ready in non-IDLE states SHALL be ignored (no queueing).
REQ-026 Latency: pass-through/error: wb_valid on 2nd edge after capture; load/store: 1 edge after ack-sampling edge; minimum 3 edges.

Reset
REQ-027 On edge with MEM_reset_n=0: state IDLE, counter 0, all outputs 0 (dmem_addr, dmem_wdata, wb_data = 32'h0).
REQ-028 Reset during REQ SHALL deassert dmem_req at that edge; later dmem_ack SHALL be ignored in IDLE.

Verification
REQ-029 Pass-through: mem_op=00000, result_data=32'h1234_5678 -> wb_valid 2 edges later, wb_data=32'h1234_5678, wb_reg_write=1.
REQ-030 LB: addr=32'h103, rdata=32'h80FF_0000, ack after 2 cycles -> dmem_addr=32'h100, wb_data=32'hFFFF_FF80; LBU -> 32'h0000_0080.
REQ-031 SH: addr=32'h202, store_data=32'hAAAA_BEEF -> dmem_wdata=32'hBEEF_BEEF, dmem_wstrb=4'b1100, dmem_we=1, wb_reg_write=0.
REQ-032 LW addr=32'h201 -> no dmem_req, mem_err=1, wb_data=0; LW aligned, ack never -> dmem_req drops after 16 edges, mem_err=1.
REQ-033 MEM_stall=1 in DONE for 3 cycles -> wb_valid stays 0, then single pulse after release; MEM_reset_n=0 mid-REQ -> dmem_req=0, busy=0 next cycle.

Source files
------------

// File: rtl/cu_mem.sv
// cu_mem: memory stage of the core.
// Captures one EX result, then either passes it straight through, rejects it
// as a malformed or misaligned access, or runs one data-memory request.
// The request ends on dmem_ack or after a 16-cycle timeout. Each completion
// is presented to write-back as a single wb_valid pulse.
//
// Ports
//   soc_clk       sole clock, rising edge
//   MEM_reset_n   synchronous active-low reset
//   MEM_stall     blocks capture in IDLE, holds the DONE state
//   result_data   EX result (address for load/store, value otherwise)
//   result_ready  EX result valid this cycle
//   store_data    rs2 value for stores
//   mem_op        [4:3] class (none/load/store/invalid), [2:0] funct3
//   dmem_*        data memory request channel (word address, byte strobes)
//   wb_data       write-back value, held until the next completion
//   wb_valid      one-cycle pulse when a completion is handed to write-back
//   wb_reg_write  completion writes a register
//   mem_err       completion was an access error or a timeout
//   busy          a transaction is in flight (state is not IDLE)
module cu_mem (
    input  logic        soc_clk,
    input  logic        MEM_reset_n,
    input  logic        MEM_stall,
    input  logic [31:0] result_data,
    input  logic        result_ready,
    input  logic [31:0] store_data,
    input  logic [4:0]  mem_op,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] wb_data,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic        mem_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic [2:0]  f3_reg;
    logic [1:0]  addr_lo_reg;

    // Decode of the incoming op; only used on the capture edge.
    logic [1:0]  op_class;
    logic [2:0]  op_f3;
    logic        f3_bad;
    logic        misaligned;
    logic        op_err;
    logic        op_store;

    assign op_class   = mem_op[4:3];
    assign op_f3      = mem_op[2:0];
    assign op_store   = (op_class == 2'b10);
    // Stores only have B/H/W; the unsigned encodings make no sense for them.
    assign f3_bad     = (op_f3 == 3'b011) || (op_f3 == 3'b110) || (op_f3 == 3'b111) ||
                        (op_store && op_f3[2]);
    // funct3[1:0]=01 covers both H and HU.
    assign misaligned = ((op_f3[1:0] == 2'b01) && result_data[0]) ||
                        ((op_f3[1:0] == 2'b10) && (result_data[1:0] != 2'b00));
    assign op_err     = (op_class == 2'b11) ||
                        ((op_class != 2'b00) && (f3_bad || misaligned));

    // Store byte lanes: B replicates the low byte everywhere, H replicates the
    // low halfword, W is taken as-is. The strobe picks the lane(s) that count.
    logic [7:0]  lane_byte [4];
    logic [31:0] store_wdata;
    logic [3:0]  store_strb;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_byte[gi] = (op_f3[1:0] == 2'b00) ? store_data[7:0] :
                                   (op_f3[1:0] == 2'b01) ? store_data[(gi % 2) * 8 +: 8] :
                                                           store_data[gi * 8 +: 8];
        end
    endgenerate

    assign store_wdata = {lane_byte[3], lane_byte[2], lane_byte[1], lane_byte[0]};

    always_comb begin
        case (op_f3[1:0])
            2'b00:   store_strb = 4'b0001 << result_data[1:0];
            2'b01:   store_strb = 4'b0011 << result_data[1:0];
            default: store_strb = 4'b1111;
        endcase
    end

    // Load alignment and extension from the latched funct3 and byte offset.
    logic [31:0] load_shifted;
    logic [31:0] load_value;

    assign load_shifted = dmem_rdata >> {addr_lo_reg, 3'b000};

    always_comb begin
        case (f3_reg)
            3'b000:  load_value = {{24{load_shifted[7]}}, load_shifted[7:0]};
            3'b001:  load_value = {{16{load_shifted[15]}}, load_shifted[15:0]};
            3'b100:  load_value = {24'h0, load_shifted[7:0]};
            3'b101:  load_value = {16'h0, load_shifted[15:0]};
            default: load_value = load_shifted;
        endcase
    end

    assign busy = (state_reg != ST_IDLE);

    always_ff @(posedge soc_clk) begin
        if (!MEM_reset_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 4'd0;
            f3_reg       <= 3'd0;
            addr_lo_reg  <= 2'd0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= 32'h0;
            dmem_wdata   <= 32'h0;
            dmem_wstrb   <= 4'h0;
            wb_data      <= 32'h0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            mem_err      <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (result_ready && !MEM_stall) begin
                        f3_reg      <= op_f3;
                        addr_lo_reg <= result_data[1:0];
                        if (op_class == 2'b00) begin
                            wb_data      <= result_data;
                            wb_reg_write <= 1'b1;
                            mem_err      <= 1'b0;
                            state_reg    <= ST_DONE;
                        end else if (op_err) begin
                            wb_data      <= 32'h0;
                            wb_reg_write <= 1'b0;
                            mem_err      <= 1'b1;
                            state_reg    <= ST_DONE;
                        end else begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= op_store;
                            dmem_addr  <= {result_data[31:2], 2'b00};
                            dmem_wdata <= op_store ? store_wdata : 32'h0;
                            dmem_wstrb <= op_store ? store_strb : 4'h0;
                            cnt_reg    <= 4'd0;
                            state_reg  <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // MEM_stall is deliberately not looked at: a bus request
                    // in flight always runs to ack or timeout.
                    if (dmem_ack) begin
                        dmem_req     <= 1'b0;
                        dmem_we      <= 1'b0;
                        wb_data      <= dmem_we ? 32'h0 : load_value;
                        wb_reg_write <= !dmem_we;
                        mem_err      <= 1'b0;
                        state_reg    <= ST_DONE;
                    end else if (cnt_reg == 4'd15) begin
                        dmem_req     <= 1'b0;
                        dmem_we      <= 1'b0;
                        wb_data      <= 32'h0;
                        wb_reg_write <= 1'b0;
                        mem_err      <= 1'b1;
                        state_reg    <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (!MEM_stall) begin
                        wb_valid  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cu_mem.sv
// Testbench for cu_mem: directed cases followed by randomized transactions,
// each checked against a behavioural model of the memory stage.
module tb_cu_mem;

    logic        soc_clk = 1'b0;
    logic        MEM_reset_n;
    logic        MEM_stall;
    logic [31:0] result_data;
    logic        result_ready;
    logic [31:0] store_data;
    logic [4:0]  mem_op;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic [31:0] wb_data;
    logic        wb_valid;
    logic        wb_reg_write;
    logic        mem_err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    // Last completion as predicted by the model; outputs must hold it.
    logic [31:0] prev_data = 32'h0;
    logic        prev_rw   = 1'b0;
    logic        prev_err  = 1'b0;

    always #5 soc_clk = ~soc_clk;

    cu_mem dut (
        .soc_clk      (soc_clk),
        .MEM_reset_n  (MEM_reset_n),
        .MEM_stall    (MEM_stall),
        .result_data  (result_data),
        .result_ready (result_ready),
        .store_data   (store_data),
        .mem_op       (mem_op),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_wstrb   (dmem_wstrb),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack),
        .wb_data      (wb_data),
        .wb_valid     (wb_valid),
        .wb_reg_write (wb_reg_write),
        .mem_err      (mem_err),
        .busy         (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (txn %0d)", tag, got, exp, n_txn);
        end
    endtask

    // 0 = pass-through, 1 = error, 2 = load, 3 = store
    function automatic int classify(input logic [4:0] op, input logic [31:0] a);
        int c;
        int f;
        c = int'(op[4:3]);
        f = int'(op[2:0]);
        if (c == 0) return 0;
        if (c == 3) return 1;
        if (f == 3 || f == 6 || f == 7) return 1;
        if (c == 2 && f >= 4) return 1;
        if ((f == 1 || f == 5) && a[0]) return 1;
        if (f == 2 && a[1:0] != 2'b00) return 1;
        return (c == 1) ? 2 : 3;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * a[1:0]);
        case (f)
            3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
            3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
            3'd4: v = v & 32'hFF;
            3'd5: v = v & 32'hFFFF;
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f, input logic [31:0] sd);
        if (f == 3'd0) return {24'h0, sd[7:0]} * 32'h0101_0101;
        if (f == 3'd1) return {16'h0, sd[15:0]} * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] f, input logic [31:0] a);
        int off;
        off = int'(a[1:0]);
        if (f == 3'd0) return 4'(1 << off);
        if (f == 3'd1) return 4'(3 << off);
        return 4'hF;
    endfunction

    // Entered at the negedge right after the edge that moved the DUT to DONE.
    task automatic finish_txn(input int stall_cyc, input logic [31:0] ed,
                              input logic erw, input logic eerr);
        result_ready = 1'b0;
        check_eq("done_wb_valid", {31'h0, wb_valid}, 32'h0);
        check_eq("done_busy", {31'h0, busy}, 32'h1);
        for (int i = 0; i < stall_cyc; i++) begin
            MEM_stall = 1'b1;
            @(negedge soc_clk);
            check_eq("stall_wb_valid", {31'h0, wb_valid}, 32'h0);
            check_eq("stall_busy", {31'h0, busy}, 32'h1);
            check_eq("stall_wb_data", wb_data, ed);
        end
        MEM_stall = 1'b0;
        @(negedge soc_clk);
        check_eq("wb_valid", {31'h0, wb_valid}, 32'h1);
        check_eq("wb_data", wb_data, ed);
        check_eq("wb_reg_write", {31'h0, wb_reg_write}, {31'h0, erw});
        check_eq("mem_err", {31'h0, mem_err}, {31'h0, eerr});
        check_eq("idle_busy", {31'h0, busy}, 32'h0);
        @(negedge soc_clk);
        check_eq("wb_valid_pulse", {31'h0, wb_valid}, 32'h0);
        prev_data = ed;
        prev_rw   = erw;
        prev_err  = eerr;
    endtask

    // One transaction, starting and ending at a negedge with the DUT in IDLE.
    // ack_dly >= 16 means the memory never answers.
    task automatic run_txn(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] sd,
                           input int ack_dly, input logic [31:0] rdata, input int stall_cyc);
        int          kind;
        bit          acked;
        logic [31:0] ed;
        logic        erw;
        logic        eerr;
        kind = classify(op, addr);
        n_txn++;
        $display("txn %0d: op=%b addr=%h sd=%h kind=%0d ack_dly=%0d stall=%0d",
                 n_txn, op, addr, sd, kind, ack_dly, stall_cyc);
        mem_op       = op;
        result_data  = addr;
        store_data   = sd;
        result_ready = 1'b1;
        MEM_stall    = 1'b0;
        dmem_ack     = 1'b0;
        @(negedge soc_clk);
        result_ready = 1'b0;
        if (kind < 2) begin
            check_eq("no_dmem_req", {31'h0, dmem_req}, 32'h0);
            if (kind == 0) finish_txn(stall_cyc, addr, 1'b1, 1'b0);
            else           finish_txn(stall_cyc, 32'h0, 1'b0, 1'b1);
        end else begin
            check_eq("dmem_req", {31'h0, dmem_req}, 32'h1);
            check_eq("dmem_we", {31'h0, dmem_we}, (kind == 3) ? 32'h1 : 32'h0);
            check_eq("dmem_addr", dmem_addr, {addr[31:2], 2'b00});
            check_eq("busy_req", {31'h0, busy}, 32'h1);
            check_eq("wb_data_hold", wb_data, prev_data);
            check_eq("wb_rw_hold", {31'h0, wb_reg_write}, {31'h0, prev_rw});
            check_eq("mem_err_hold", {31'h0, mem_err}, {31'h0, prev_err});
            if (kind == 3) begin
                check_eq("dmem_wdata", dmem_wdata, model_wdata(op[2:0], sd));
                check_eq("dmem_wstrb", {28'h0, dmem_wstrb}, {28'h0, model_strb(op[2:0], addr)});
            end
            acked = 1'b0;
            for (int k = 0; k < 16 && !acked; k++) begin
                if (k == ack_dly) begin
                    dmem_ack     = 1'b1;
                    dmem_rdata   = rdata;
                    result_ready = 1'b0;
                    MEM_stall    = 1'b0;
                    acked        = 1'b1;
                    @(negedge soc_clk);
                    dmem_ack = 1'b0;
                end else begin
                    // Noise that the DUT must ignore while the request is open.
                    dmem_ack     = 1'b0;
                    dmem_rdata   = $urandom;
                    result_ready = 1'($urandom_range(0, 1));
                    MEM_stall    = 1'($urandom_range(0, 1));
                    @(negedge soc_clk);
                    if (k < 15) begin
                        check_eq("req_held", {31'h0, dmem_req}, 32'h1);
                        check_eq("addr_held", dmem_addr, {addr[31:2], 2'b00});
                    end
                end
            end
            result_ready = 1'b0;
            MEM_stall    = 1'b0;
            check_eq("req_dropped", {31'h0, dmem_req}, 32'h0);
            check_eq("we_dropped", {31'h0, dmem_we}, 32'h0);
            if (!acked) begin
                ed = 32'h0; erw = 1'b0; eerr = 1'b1;
            end else if (kind == 2) begin
                ed = model_load(op[2:0], addr, rdata); erw = 1'b1; eerr = 1'b0;
            end else begin
                ed = 32'h0; erw = 1'b0; eerr = 1'b0;
            end
            finish_txn(stall_cyc, ed, erw, eerr);
        end
    endtask

    initial begin
        MEM_reset_n  = 1'b0;
        MEM_stall    = 1'b0;
        result_data  = 32'h0;
        result_ready = 1'b0;
        store_data   = 32'h0;
        mem_op       = 5'h0;
        dmem_rdata   = 32'h0;
        dmem_ack     = 1'b0;
        repeat (3) @(negedge soc_clk);
        check_eq("rst_busy", {31'h0, busy}, 32'h0);
        check_eq("rst_dmem_req", {31'h0, dmem_req}, 32'h0);
        check_eq("rst_dmem_addr", dmem_addr, 32'h0);
        check_eq("rst_dmem_wdata", dmem_wdata, 32'h0);
        check_eq("rst_wb_data", wb_data, 32'h0);
        check_eq("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
        check_eq("rst_mem_err", {31'h0, mem_err}, 32'h0);
        MEM_reset_n = 1'b1;
        @(negedge soc_clk);

        // Directed cases
        run_txn(5'b00_000, 32'h1234_5678, 32'h0, 0, 32'h0, 0);          // pass-through
        run_txn(5'b01_000, 32'h0000_0103, 32'h0, 2, 32'h80FF_0000, 0);  // LB
        run_txn(5'b01_100, 32'h0000_0103, 32'h0, 2, 32'h80FF_0000, 0);  // LBU
        run_txn(5'b10_001, 32'h0000_0202, 32'hAAAA_BEEF, 1, 32'h0, 0);  // SH
        run_txn(5'b01_010, 32'h0000_0201, 32'h0, 0, 32'h0, 0);          // LW misaligned
        run_txn(5'b01_010, 32'h0000_0200, 32'h0, 16, 32'h0, 0);         // LW timeout
        run_txn(5'b01_010, 32'h0000_0300, 32'h0, 15, 32'hCAFE_F00D, 0); // ack on last edge
        run_txn(5'b00_000, 32'hDEAD_BEEF, 32'h0, 0, 32'h0, 3);          // stall in DONE
        run_txn(5'b10_100, 32'h0000_0400, 32'h1, 0, 32'h0, 0);          // store funct3 1xx
        run_txn(5'b11_000, 32'h0000_0400, 32'h1, 0, 32'h0, 0);          // invalid class

        // Reset in the middle of a request
        n_txn++;
        $display("txn %0d: reset during REQ", n_txn);
        mem_op       = 5'b01_010;
        result_data  = 32'h0000_0500;
        result_ready = 1'b1;
        @(negedge soc_clk);
        result_ready = 1'b0;
        check_eq("mr_req", {31'h0, dmem_req}, 32'h1);
        @(negedge soc_clk);
        MEM_reset_n = 1'b0;
        @(negedge soc_clk);
        check_eq("mr_req_drop", {31'h0, dmem_req}, 32'h0);
        check_eq("mr_busy", {31'h0, busy}, 32'h0);
        check_eq("mr_addr", dmem_addr, 32'h0);
        check_eq("mr_wb_data", wb_data, 32'h0);
        MEM_reset_n = 1'b1;
        dmem_ack    = 1'b1;
        dmem_rdata  = 32'h1111_2222;
        @(negedge soc_clk);
        dmem_ack = 1'b0;
        check_eq("late_ack_busy", {31'h0, busy}, 32'h0);
        check_eq("late_ack_wb_data", wb_data, 32'h0);
        @(negedge soc_clk);
        check_eq("late_ack_wb_valid", {31'h0, wb_valid}, 32'h0);
        prev_data = 32'h0;
        prev_rw   = 1'b0;
        prev_err  = 1'b0;

        // Randomized transactions
        for (int t = 0; t < 200; t++) begin
            logic [4:0]  op;
            logic [31:0] a;
            int          r;
            int          dly;
            op  = 5'($urandom_range(0, 31));
            a   = $urandom;
            r   = $urandom_range(0, 9);
            dly = (r == 9) ? 16 : (r % 4);
            run_txn(op, a, $urandom, dly, $urandom, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
